// File: rtl/mac_pe_ws.sv
// Weight-stationary systolic PE: holds one weight, multiplies the west activation,
// adds the north partial sum and registers the result south.
module mac_pe_ws #(
    parameter int abw     = 2,
    parameter int wbw     = 4,
    parameter int psum_bw = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [abw-1:0]     act_in,
    input  logic [wbw-1:0]     wt_in,
    input  logic [2:0]         inst_w,
    input  logic               act_signed,
    input  logic               sat_en,
    input  logic [psum_bw-1:0] in_n,
    output logic [abw-1:0]     act_out,
    output logic [wbw-1:0]     wt_out,
    output logic [2:0]         inst_e,
    output logic [psum_bw-1:0] out_s,
    output logic               valid_s,
    output logic               loaded,
    output logic               ovf
);
    localparam int PW = abw + wbw + 1;
    localparam int SW = psum_bw + 1;

    typedef enum logic {EMPTY, LOADED} state_t;

    state_t                    state_q;
    logic signed [wbw-1:0]     w_q;
    logic [abw-1:0]            act_out_q;
    logic [wbw-1:0]            wt_out_q;
    logic [2:0]                inst_e_q;
    logic [psum_bw-1:0]        out_s_q, out_s_d;
    logic                      valid_s_q;
    logic                      ovf_q;

    logic                      ld, ex, fl, fwd_load, ovf_d;
    logic signed [abw:0]       act_x;
    logic signed [PW-1:0]      prod;
    logic signed [SW-1:0]      sum;

    assign ld = inst_w[0];
    assign ex = inst_w[1];
    assign fl = inst_w[2];
    // A load only travels east once this PE already owns its weight; flush suppresses it.
    assign fwd_load = ld && !fl && (state_q == LOADED);

    always_comb begin
        act_x = act_signed ? {act_in[abw-1], act_in} : {1'b0, act_in};
        prod  = (state_q == LOADED) ? PW'(act_x) * PW'(w_q) : '0;
        sum   = SW'($signed(in_n)) + SW'(prod);
        // The sum always fits in SW bits, so overflow shows up as the top two bits disagreeing.
        ovf_d = sum[SW-1] ^ sum[SW-2];
        out_s_d = sum[psum_bw-1:0];
        if (ovf_d && sat_en)
            out_s_d = sum[SW-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            w_q       <= '0;
            act_out_q <= '0;
            wt_out_q  <= '0;
            inst_e_q  <= '0;
            out_s_q   <= '0;
            valid_s_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            act_out_q <= act_in;
            inst_e_q  <= {fl, ex, fwd_load};
            if (fwd_load) wt_out_q <= wt_in;
            valid_s_q <= ex;
            if (ex) out_s_q <= out_s_d;
            if (fl) begin
                state_q <= EMPTY;
                ovf_q   <= 1'b0;
            end else begin
                if (ld && state_q == EMPTY) begin
                    state_q <= LOADED;
                    w_q     <= $signed(wt_in);
                end
                if (ex && ovf_d) ovf_q <= 1'b1;
            end
        end
    end

    assign act_out = act_out_q;
    assign wt_out  = wt_out_q;
    assign inst_e  = inst_e_q;
    assign out_s   = out_s_q;
    assign valid_s = valid_s_q;
    assign loaded  = (state_q == LOADED);
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_mac_pe_ws.sv
// Directed plus random bench for mac_pe_ws against an integer-arithmetic reference model.
module tb_mac_pe_ws;
    localparam int ABW = 2, WBW = 4, PBW = 10;
    localparam int PMAX = 2**(PBW-1) - 1;
    localparam int PMIN = -(2**(PBW-1));

    logic           clk = 1'b0;
    logic           reset;
    logic [ABW-1:0] act_in;
    logic [WBW-1:0] wt_in;
    logic [2:0]     inst_w;
    logic           act_signed, sat_en;
    logic [PBW-1:0] in_n;
    logic [ABW-1:0] act_out;
    logic [WBW-1:0] wt_out;
    logic [2:0]     inst_e;
    logic [PBW-1:0] out_s;
    logic           valid_s, loaded, ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_loaded, m_w, m_act_out, m_wt_out, m_inst_e, m_out_s, m_valid, m_ovf;

    always #5 clk = ~clk;

    mac_pe_ws #(.abw(ABW), .wbw(WBW), .psum_bw(PBW)) dut (
        .clk(clk), .reset(reset), .act_in(act_in), .wt_in(wt_in), .inst_w(inst_w),
        .act_signed(act_signed), .sat_en(sat_en), .in_n(in_n),
        .act_out(act_out), .wt_out(wt_out), .inst_e(inst_e), .out_s(out_s),
        .valid_s(valid_s), .loaded(loaded), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] iw, input logic [ABW-1:0] a,
                        input logic [WBW-1:0] wt, input logic as, input logic se,
                        input logic [PBW-1:0] n);
        int av, wv, s, r, nn;
        reset = rst; inst_w = iw; act_in = a; wt_in = wt;
        act_signed = as; sat_en = se; in_n = n;
        if (rst) begin
            m_loaded = 0; m_w = 0; m_act_out = 0; m_wt_out = 0; m_inst_e = 0;
            m_out_s = 0; m_valid = 0; m_ovf = 0;
        end else begin
            av = int'(a);
            if (as && av >= 2**(ABW-1)) av -= 2**ABW;
            wv = m_loaded ? m_w : 0;
            nn = $signed(n);
            s  = nn + av * wv;
            if (s > PMAX || s < PMIN) begin
                if (se) r = (s > PMAX) ? PMAX : PMIN;
                else begin
                    r = s & (2**PBW - 1);
                    if (r > PMAX) r -= 2**PBW;
                end
            end else r = s;
            m_act_out = int'(a);
            m_inst_e  = (iw[2] ? 4 : 0) + (iw[1] ? 2 : 0) + ((iw[0] && !iw[2] && m_loaded != 0) ? 1 : 0);
            if (m_inst_e % 2 == 1) m_wt_out = int'(wt);
            m_valid = iw[1];
            if (iw[1]) m_out_s = r;
            if (iw[2]) begin
                m_loaded = 0; m_ovf = 0;
            end else begin
                if (iw[1] && (s > PMAX || s < PMIN)) m_ovf = 1;
                if (iw[0] && m_loaded == 0) begin
                    m_loaded = 1; m_w = $signed(wt);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("act_out", 32'(act_out), 32'(m_act_out[ABW-1:0]));
        chk("wt_out",  32'(wt_out),  32'(m_wt_out[WBW-1:0]));
        chk("inst_e",  32'(inst_e),  32'(m_inst_e[2:0]));
        chk("out_s",   32'(out_s),   32'(m_out_s[PBW-1:0]));
        chk("valid_s", 32'(valid_s), 32'(m_valid[0]));
        chk("loaded",  32'(loaded),  32'(m_loaded[0]));
        chk("ovf",     32'(ovf),     32'(m_ovf[0]));
    endtask

    initial begin
        reset = 1'b1; inst_w = '0; act_in = '0; wt_in = '0;
        act_signed = 1'b0; sat_en = 1'b0; in_n = '0;
        #1;

        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 3'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 10'($urandom));
        chk("rst_out_s", 32'(out_s), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);

        // Load chain: -3, then a second load forwarded east
        step(1'b0, 3'b001, 2'd0, 4'b1101, 1'b0, 1'b0, 10'd0);
        chk("load_loaded", 32'(loaded), 32'd1);
        step(1'b0, 3'b001, 2'd0, 4'd5, 1'b0, 1'b0, 10'd0);
        chk("fwd_wt_out", 32'(wt_out), 32'd5);
        chk("fwd_inst_e0", 32'(inst_e[0]), 32'd1);

        // Unsigned and signed MAC with weight -3
        step(1'b0, 3'b010, 2'd3, 4'd0, 1'b0, 1'b0, 10'd10);
        chk("mac_unsigned", 32'(out_s), 32'd1);
        chk("mac_valid", 32'(valid_s), 32'd1);
        step(1'b0, 3'b010, 2'b11, 4'd0, 1'b1, 1'b0, 10'd0);
        chk("mac_signed", 32'(out_s), 32'd3);
        step(1'b0, 3'b000, 2'd1, 4'd0, 1'b0, 1'b0, 10'd77);
        chk("hold_valid", 32'(valid_s), 32'd0);
        chk("hold_out_s", 32'(out_s), 32'd3);

        // Overflow with weight 7
        step(1'b0, 3'b100, 2'd0, 4'd0, 1'b0, 1'b0, 10'd0);
        step(1'b0, 3'b001, 2'd0, 4'd7, 1'b0, 1'b0, 10'd0);
        step(1'b0, 3'b010, 2'd3, 4'd0, 1'b0, 1'b1, 10'd510);
        chk("sat_out_s", 32'(out_s), 32'd511);
        chk("sat_ovf", 32'(ovf), 32'd1);
        step(1'b0, 3'b010, 2'd3, 4'd0, 1'b0, 1'b0, 10'd510);
        chk("wrap_out_s", 32'(out_s), 32'h213);
        chk("wrap_ovf", 32'(ovf), 32'd1);

        // Flush, then pass-through while EMPTY
        step(1'b0, 3'b100, 2'd0, 4'd0, 1'b0, 1'b0, 10'd0);
        chk("flush_loaded", 32'(loaded), 32'd0);
        chk("flush_ovf", 32'(ovf), 32'd0);
        step(1'b0, 3'b010, 2'd3, 4'd0, 1'b0, 1'b0, 10'h3F9);
        chk("pass_out_s", 32'(out_s), 32'h3F9);

        // Execute+load while EMPTY passes through, then weight 2 applies
        step(1'b0, 3'b011, 2'd3, 4'd2, 1'b0, 1'b0, 10'd4);
        chk("exld_out_s", 32'(out_s), 32'd4);
        step(1'b0, 3'b010, 2'd3, 4'd0, 1'b0, 1'b0, 10'd4);
        chk("exld_next", 32'(out_s), 32'd10);

        // Reset mid-stream, then a continuous execute stream
        step(1'b1, 3'b010, 2'd3, 4'd0, 1'b0, 1'b0, 10'd100);
        chk("mid_rst_valid", 32'(valid_s), 32'd0);
        chk("mid_rst_out_s", 32'(out_s), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b010, 2'd1, 4'd0, 1'b0, 1'b0, 10'(20 + i));
            chk("stream_valid", 32'(valid_s), 32'd1);
            chk("stream_out_s", 32'(out_s), 32'(20 + i));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 3'($urandom), 2'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_pe_ws.md
# mac_pe_ws

Weight-stationary, registered processing element for the systolic MAC array. It is the parametrised successor of the combinational `mac` datapath. Each instance holds one weight and multiplies it by the activation streaming in from the west. It adds the product to the partial sum arriving from the north and registers the result southward. Added behaviour: selectable signed or unsigned activations, saturating or wrapping accumulation, weight daisy-chain loading, flush, and a sticky overflow flag.

## Interface
Parameters:
- `abw`, 2: activation bitwidth
- `wbw`, 4: weight bitwidth (signed)
- `psum_bw`, 10: partial-sum bitwidth (signed)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `act_in`  in  abw  activation from west
- `wt_in`  in  wbw  weight from west (load chain)
- `inst_w`  in  3  [0] load, [1] execute, [2] flush
- `act_signed`  in  1  1: `act_in` is two's complement; 0: unsigned
- `sat_en`  in  1  1: saturate the sum; 0: wrap
- `in_n`  in  psum_bw  partial sum from north
- `act_out`  out  abw  registered `act_in` to east
- `wt_out`  out  wbw  forwarded weight to east
- `inst_e`  out  3  registered instruction to east
- `out_s`  out  psum_bw  registered partial sum to south
- `valid_s`  out  1  `out_s` updated this cycle
- `loaded`  out  1  weight register holds a valid weight
- `ovf`  out  1  sticky overflow/saturation flag

## Operation
- State machine with two states:
  - EMPTY → LOADED on `inst_w[0]` while EMPTY: `wt_in` is captured into `w_q`.
  - LOADED → EMPTY on `inst_w[2]`.
- Load while LOADED: `w_q` is unchanged. `wt_in` is registered to `wt_out` and `inst_e[0]` is set, so the next PE receives the load. Load while EMPTY: `inst_e[0]` = 0 and `wt_out` holds.
- Flush has priority over load in the same cycle: the state goes to EMPTY, `ovf` clears, and `w_q` is left unchanged. Flush is forwarded on `inst_e[2]`.
- Execute (`inst_w[1]`):
  - Activation extension: `act_signed`=0 zero-extends `act_in` to abw+1 bits; `act_signed`=1 sign-extends it.
  - Product: abw+wbw+1 bits, signed, equal to extended activation × `w_q`.
  - Sum: computed at psum_bw+1 bits, equal to `in_n` sign-extended plus the product sign-extended.
  - With `sat_en`=1, the sum is clamped to [−2^(psum_bw−1), 2^(psum_bw−1)−1]. With `sat_en`=0, the sum is truncated to psum_bw bits.
  - Overflow (sum outside the range above) sets `ovf` in either mode.
- Execute while EMPTY: `out_s` ← `in_n` (pass-through, product treated as 0), `valid_s`=1, `ovf` unaffected.
- Execute and load in the same cycle while EMPTY: the product uses weight 0 (pass-through), and the load captures the weight for subsequent cycles. While LOADED, execute uses the current `w_q`.
- `act_out` and `inst_e[1]` are registered every cycle, regardless of state.

## Timing
- Reset (synchronous): all outputs = 0, state EMPTY, `w_q` = 0. Reset overrides every `inst_w` bit.
- Reset asserted mid-stream discards the in-flight result. `valid_s` = 0 in the cycle after reset.
- Latency is one cycle everywhere:
  - `act_in`/`inst_w` → `act_out`/`inst_e`
  - execute → `out_s`/`valid_s`
  - load → `loaded`
- `out_s` holds its value in cycles without execute. `valid_s` is high for exactly the cycle after each execute.
- Back-to-back executes produce one result per cycle with no bubbles.
- `ovf` stays high until reset or flush. If flush and an overflowing execute occur in the same cycle, flush wins and `ovf` = 0.
- `loaded` mirrors the state register: it rises in the cycle after the first load and falls in the cycle after flush.

## Test plan
Parameters for all scenarios: abw=2, wbw=4, psum_bw=10.
- Reset: hold `reset` 2 cycles with random inputs → all outputs 0, `loaded`=0.
- Load chain:
  - load with `wt_in`=4'b1101 → `loaded`=1 next cycle.
  - second load with `wt_in`=5 → `wt_out`=5 and `inst_e[0]`=1 next cycle, `w_q` still −3.
- Unsigned and signed MAC with weight −3:
  - `act_in`=3, `act_signed`=0, `in_n`=10, execute → `out_s`=1 and `valid_s`=1 one cycle later.
  - `act_in`=2'b11, `act_signed`=1, `in_n`=0 → `out_s`=3.
- Overflow with weight 7, `act_in`=3, `in_n`=510 (sum 531):
  - `sat_en`=1 → `out_s`=511, `ovf`=1.
  - `sat_en`=0 → `out_s`=−493, `ovf`=1.
- Flush plus execute while EMPTY: flush → `loaded`=0 and `ovf`=0; execute with `in_n`=−7 → `out_s`=−7.
- Reset mid-stream: execute in cycle N with `reset` in cycle N → `valid_s`=0 and `out_s`=0 at N+1; a continuous execute stream resumes one result per cycle after reset is released.
